// File: rtl/wb_regfile_if.sv
// MEM/WB-to-regfile bus: write-back inputs, ID-stage read ports, forwarding and retire-count outputs.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
);
    logic              RegWrite;
    logic              MemtoReg;
    logic [DATA_W-1:0] ReadData;
    logic [DATA_W-1:0] ALU_result;
    logic [4:0]        destination_reg;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] WriteData;
    logic [CNT_W-1:0]  wb_count;

    modport master (
        output RegWrite, MemtoReg, ReadData, ALU_result, destination_reg, rs1, rs2,
        input  ReadData1, ReadData2, WriteData, wb_count
    );

    modport slave (
        input  RegWrite, MemtoReg, ReadData, ALU_result, destination_reg, rs1, rs2,
        output ReadData1, ReadData2, WriteData, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back mux, 32 x DATA_W integer register file (x0 hardwired to zero) and retired-write counter.
// Define WB_BYPASS_EN for write-first read ports; default build returns stored contents only.
module wb_regfile #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input logic          clk,
    input logic          reset,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] write_data;
    logic              wr_en;
    logic [CNT_W-1:0]  wb_count_q;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    always_comb begin
        write_data = bus.MemtoReg ? bus.ReadData : bus.ALU_result;
        wr_en      = bus.RegWrite && (bus.destination_reg != 5'd0);
    end

    // Reset dominates any simultaneous write; x0 is never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            wb_count_q <= '0;
        end else if (wr_en) begin
            regs[bus.destination_reg] <= write_data;
            wb_count_q                <= wb_count_q + CNT_W'(1);
        end
    end

    always_comb begin
        rd1 = (bus.rs1 == 5'd0) ? '0 : regs[bus.rs1];
        rd2 = (bus.rs2 == 5'd0) ? '0 : regs[bus.rs2];
`ifdef WB_BYPASS_EN
        // wr_en already excludes rd=0, so a bypass can never leak into x0 reads.
        if (wr_en && (bus.rs1 == bus.destination_reg)) rd1 = write_data;
        if (wr_en && (bus.rs2 == bus.destination_reg)) rd2 = write_data;
`endif
    end

    always_comb begin
        bus.ReadData1 = rd1;
        bus.ReadData2 = rd2;
        bus.WriteData = write_data;
        bus.wb_count  = wb_count_q;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: reference register model plus a queue of expected values.
module tb_wb_regfile;

    logic clk = 1'b0;
    logic reset;
    logic reset4;

    wb_regfile_if #(.DATA_W(64), .CNT_W(32)) bus ();
    wb_regfile_if #(.DATA_W(64), .CNT_W(4))  bus4 ();

    wb_regfile #(.DATA_W(64), .CNT_W(32)) dut  (.clk(clk), .reset(reset),  .bus(bus));
    wb_regfile #(.DATA_W(64), .CNT_W(4))  dut4 (.clk(clk), .reset(reset4), .bus(bus4));

    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mregs [32];
    logic [31:0] mcnt;

    function automatic logic [63:0] m_wd();
        return bus.MemtoReg ? bus.ReadData : bus.ALU_result;
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
        if (BYP && bus.RegWrite && bus.destination_reg != 5'd0 && idx == bus.destination_reg)
            return m_wd();
        return mregs[idx];
    endfunction

    task automatic drive(input logic rw, input logic mtr, input logic [4:0] rd,
                         input logic [63:0] rdata, input logic [63:0] alu,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.RegWrite        = rw;
        bus.MemtoReg        = mtr;
        bus.destination_reg = rd;
        bus.ReadData        = rdata;
        bus.ALU_result      = alu;
        bus.rs1             = r1;
        bus.rs2             = r2;
    endtask

    // Advance the model with the inputs held at the edge, then move to just after the edge.
    task automatic edge_main();
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
            mcnt = 32'd0;
        end else if (bus.RegWrite && bus.destination_reg != 5'd0) begin
            mregs[bus.destination_reg] = m_wd();
            mcnt = mcnt + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] e;
        reset = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd0);
        edge_main();
        reset = 1'b0;
        drive(1'b1, 1'b0, 5'd5, 64'd0, 64'hAAAA, 5'd5, 5'd0);
        exp_q.push_back(64'hAAAA);
        edge_main();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd5, 5'd0);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData1 !== e) begin
            miscompares++; $display("FAIL pre_reset_x5: got %h expected %h", bus.ReadData1, e);
        end
        reset = 1'b1;
        drive(1'b1, 1'b0, 5'd5, 64'd0, 64'hDEAD, 5'd5, 5'd0);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        edge_main();
        edge_main();
        reset = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd5, 5'd0);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData1 !== e) begin
            miscompares++; $display("FAIL reset_x5: got %h expected %h", bus.ReadData1, e);
        end
        e = exp_q.pop_front(); vectors++;
        if ({32'd0, bus.wb_count} !== e) begin
            miscompares++; $display("FAIL reset_count: got %0d expected %0d", bus.wb_count, e);
        end
    endtask

    task automatic test_alu_commit();
        logic [63:0] e;
        drive(1'b1, 1'b0, 5'd3, 64'hFFFF, 64'h1234_5678_9ABC_DEF0, 5'd0, 5'd3);
        exp_q.push_back(64'h1234_5678_9ABC_DEF0);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.WriteData !== e) begin
            miscompares++; $display("FAIL alu_wd: got %h expected %h", bus.WriteData, e);
        end
        exp_q.push_back(64'h1234_5678_9ABC_DEF0);
        exp_q.push_back(64'd1);
        edge_main();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd3);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData2 !== e) begin
            miscompares++; $display("FAIL alu_x3: got %h expected %h", bus.ReadData2, e);
        end
        e = exp_q.pop_front(); vectors++;
        if ({32'd0, bus.wb_count} !== e) begin
            miscompares++; $display("FAIL alu_count: got %0d expected %0d", bus.wb_count, e);
        end
    endtask

    task automatic test_load_commit();
        logic [63:0] e;
        drive(1'b1, 1'b1, 5'd31, 64'h0000_0000_CAFE_F00D, 64'h5555, 5'd0, 5'd0);
        exp_q.push_back(64'hCAFEF00D);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.WriteData !== e) begin
            miscompares++; $display("FAIL load_wd: got %h expected %h", bus.WriteData, e);
        end
        exp_q.push_back(64'hCAFEF00D);
        edge_main();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd31, 5'd0);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData1 !== e) begin
            miscompares++; $display("FAIL load_x31: got %h expected %h", bus.ReadData1, e);
        end
    endtask

    task automatic test_x0_guard();
        logic [63:0] e;
        logic [31:0] cnt_before;
        cnt_before = mcnt;
        drive(1'b1, 1'b0, 5'd0, 64'd0, 64'h77, 5'd0, 5'd0);
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData1 !== e) begin
            miscompares++; $display("FAIL x0_pre: got %h expected %h", bus.ReadData1, e);
        end
        exp_q.push_back(64'd0);
        exp_q.push_back({32'd0, cnt_before});
        edge_main();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd0);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData1 !== e) begin
            miscompares++; $display("FAIL x0_post: got %h expected %h", bus.ReadData1, e);
        end
        e = exp_q.pop_front(); vectors++;
        if ({32'd0, bus.wb_count} !== e) begin
            miscompares++; $display("FAIL x0_count: got %0d expected %0d", bus.wb_count, e);
        end
    endtask

    task automatic test_same_cycle();
        logic [63:0] e;
        drive(1'b1, 1'b0, 5'd7, 64'd0, 64'h11, 5'd0, 5'd0);
        edge_main();
        drive(1'b1, 1'b0, 5'd7, 64'd0, 64'h22, 5'd7, 5'd7);
        exp_q.push_back(BYP ? 64'h22 : 64'h11);
        exp_q.push_back(BYP ? 64'h22 : 64'h11);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData1 !== e) begin
            miscompares++; $display("FAIL same_rd1_pre: got %h expected %h", bus.ReadData1, e);
        end
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData2 !== e) begin
            miscompares++; $display("FAIL same_rd2_pre: got %h expected %h", bus.ReadData2, e);
        end
        exp_q.push_back(64'h22);
        exp_q.push_back(64'h22);
        edge_main();
        drive(1'b0, 1'b0, 5'd7, 64'd0, 64'h33, 5'd7, 5'd7);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData1 !== e) begin
            miscompares++; $display("FAIL same_rd1_post: got %h expected %h", bus.ReadData1, e);
        end
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData2 !== e) begin
            miscompares++; $display("FAIL same_rd2_post: got %h expected %h", bus.ReadData2, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        logic [4:0]  rd;
        for (int n = 0; n < 48; n++) begin
            rd = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rd,
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
            exp_q.push_back(m_read(bus.rs1));
            exp_q.push_back(m_read(bus.rs2));
            exp_q.push_back(m_wd());
            #1;
            e = exp_q.pop_front(); vectors++;
            if (bus.ReadData1 !== e) begin
                miscompares++; $display("FAIL b2b_rd1[%0d]: got %h expected %h", n, bus.ReadData1, e);
            end
            e = exp_q.pop_front(); vectors++;
            if (bus.ReadData2 !== e) begin
                miscompares++; $display("FAIL b2b_rd2[%0d]: got %h expected %h", n, bus.ReadData2, e);
            end
            e = exp_q.pop_front(); vectors++;
            if (bus.WriteData !== e) begin
                miscompares++; $display("FAIL b2b_wd[%0d]: got %h expected %h", n, bus.WriteData, e);
            end
            edge_main();
            vectors++;
            if (bus.wb_count !== mcnt) begin
                miscompares++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", n, bus.wb_count, mcnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] e;
        drive(1'b1, 1'b0, 5'd9, 64'd0, 64'h99, 5'd0, 5'd0);
        edge_main();
        reset = 1'b1;
        drive(1'b1, 1'b0, 5'd10, 64'd0, 64'h55, 5'd0, 5'd0);
        edge_main();
        reset = 1'b0;
        exp_q.push_back(64'h55);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        edge_main();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd10, 5'd9);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData1 !== e) begin
            miscompares++; $display("FAIL mid_x10: got %h expected %h", bus.ReadData1, e);
        end
        e = exp_q.pop_front(); vectors++;
        if (bus.ReadData2 !== e) begin
            miscompares++; $display("FAIL mid_x9: got %h expected %h", bus.ReadData2, e);
        end
        e = exp_q.pop_front(); vectors++;
        if ({32'd0, bus.wb_count} !== e) begin
            miscompares++; $display("FAIL mid_count: got %0d expected %0d", bus.wb_count, e);
        end
    endtask

    task automatic test_counter_wrap();
        logic [63:0] e;
        @(posedge clk); #1;
        reset4 = 1'b0;
        bus4.RegWrite        = 1'b1;
        bus4.MemtoReg        = 1'b0;
        bus4.destination_reg = 5'd1;
        bus4.rs1             = 5'd1;
        for (int i = 0; i < 16; i++) begin
            bus4.ALU_result = 64'(i);
            exp_q.push_back(64'((i + 1) % 16));
            @(posedge clk); #1;
            e = exp_q.pop_front(); vectors++;
            if (bus4.wb_count !== e[3:0]) begin
                miscompares++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, bus4.wb_count, e[3:0]);
            end
        end
        bus4.RegWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(64'd0);
            @(posedge clk); #1;
            e = exp_q.pop_front(); vectors++;
            if (bus4.wb_count !== e[3:0]) begin
                miscompares++; $display("FAIL wrap_idle[%0d]: got %0d expected %0d", i, bus4.wb_count, e[3:0]);
            end
        end
        e = 64'd15; vectors++;
        if (bus4.ReadData1 !== e) begin
            miscompares++; $display("FAIL wrap_x1: got %h expected %h", bus4.ReadData1, e);
        end
    endtask

    initial begin
        reset  = 1'b1;
        reset4 = 1'b1;
        mcnt   = 32'd0;
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd0);
        bus4.RegWrite        = 1'b0;
        bus4.MemtoReg        = 1'b0;
        bus4.ReadData        = 64'd0;
        bus4.ALU_result      = 64'd0;
        bus4.destination_reg = 5'd0;
        bus4.rs1             = 5'd0;
        bus4.rs2             = 5'd0;
        #2;
        test_reset();
        test_alu_commit();
        test_load_commit();
        test_x0_guard();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd0);
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
